// File: rtl/vscpu_pkg.sv
// Shared constants for the VerySimpleCPU memory arbiter slice: FSM encoding and bus widths.
package vscpu_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam int VSCPU_ADDR_W = 14;
  localparam int VSCPU_DATA_W = 32;

endpackage

// File: rtl/vscpu_mem_arbiter_if.sv
// Core-side and controller-side bus of the memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding cores plus controller.
interface vscpu_mem_arbiter_if
  import vscpu_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = VSCPU_ADDR_W,
  parameter int DATA_W  = VSCPU_DATA_W
);

  logic [NUM_REQ-1:0]        cpu_req;
  logic [NUM_REQ-1:0]        cpu_we;
  logic [NUM_REQ*ADDR_W-1:0] cpu_addr;
  logic [NUM_REQ*DATA_W-1:0] cpu_wdata;
  logic [NUM_REQ-1:0]        cpu_vld;
  logic [DATA_W-1:0]         cpu_rdata;
  logic                      mem_req;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      mem_vld;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_vld,
    output cpu_vld, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata, grant, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_vld,
    input  cpu_vld, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata, grant, busy
  );

endinterface

// File: rtl/vscpu_rr_pick.sv
// Combinational round-robin picker: first requester at or after (last+1) mod NUM_REQ.
module vscpu_rr_pick #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Scan from farthest to nearest candidate so the nearest requester is written last and wins.
  always_comb begin
    logic [IDX_W-1:0] cand_s;
    cand_s = {IDX_W{1'b0}};
    valid  = 1'b0;
    idx    = {IDX_W{1'b0}};
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_s = IDX_W'((int'(last) + k) % NUM_REQ);
      valid  = valid | req[cand_s];
      idx    = req[cand_s] ? cand_s : idx;
    end
  end

endmodule

// File: rtl/vscpu_mem_arbiter.sv
// Round-robin arbiter sharing one memory-controller port between NUM_REQ VerySimpleCPU cores.
// One access in flight at a time; IDLE -> ACCESS -> DONE, every output registered.
module vscpu_mem_arbiter
  import vscpu_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = VSCPU_ADDR_W,
  parameter int DATA_W  = VSCPU_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  vscpu_mem_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [1:0]         state_r;
  logic [IDX_W-1:0]   last_grant_r;
  logic [NUM_REQ-1:0] cpu_vld_r;
  logic [DATA_W-1:0]  cpu_rdata_r;
  logic               mem_req_r;
  logic               mem_we_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [DATA_W-1:0]  mem_wdata_r;
  logic [NUM_REQ-1:0] grant_r;
  logic               busy_r;
  logic               pick_valid_s;
  logic [IDX_W-1:0]   pick_idx_s;

  vscpu_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (bus.cpu_req),
    .last  (last_grant_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // Arbitration FSM; last_grant_r doubles as the owner index of the access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      last_grant_r <= IDX_W'(NUM_REQ - 1);
      cpu_vld_r    <= {NUM_REQ{1'b0}};
      cpu_rdata_r  <= {DATA_W{1'b0}};
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {DATA_W{1'b0}};
      grant_r      <= {NUM_REQ{1'b0}};
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            mem_req_r    <= 1'b1;
            mem_we_r     <= bus.cpu_we[pick_idx_s];
            mem_addr_r   <= bus.cpu_addr[int'(pick_idx_s) * ADDR_W +: ADDR_W];
            mem_wdata_r  <= bus.cpu_wdata[int'(pick_idx_s) * DATA_W +: DATA_W];
            grant_r      <= ONE_HOT0 << pick_idx_s;
            last_grant_r <= pick_idx_s;
            busy_r       <= 1'b1;
            state_r      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (bus.mem_vld) begin
            mem_req_r   <= 1'b0;
            cpu_rdata_r <= bus.mem_rdata;
            cpu_vld_r   <= ONE_HOT0 << last_grant_r;
            state_r     <= ST_DONE;
          end
        end
        // Bubble cycle: lets the owner drop cpu_req before the next arbitration.
        ST_DONE: begin
          cpu_vld_r <= {NUM_REQ{1'b0}};
          grant_r   <= {NUM_REQ{1'b0}};
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          cpu_vld_r <= {NUM_REQ{1'b0}};
          mem_req_r <= 1'b0;
          grant_r   <= {NUM_REQ{1'b0}};
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_vld   = cpu_vld_r;
  assign bus.cpu_rdata = cpu_rdata_r;
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.grant     = grant_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_vscpu_mem_arbiter.sv
// Self-checking bench for vscpu_mem_arbiter: directed scenarios then randomized traffic,
// checked against a round-robin reference model (nearest pending core after the last served one).
module tb_vscpu_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 14;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vscpu_mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  vscpu_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Core-side view held by the bench and reference-model state.
  logic [N-1:0]  req_v;
  logic [N-1:0]  we_v;
  logic [AW-1:0] addr_a  [N];
  logic [DW-1:0] wdata_a [N];
  bit            keep_a  [N];
  int            wait_cnt[N];
  int            last_served;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Pending core with the smallest rotational distance from last_served+1.
  function automatic int model_pick();
    int best  = -1;
    int bestd = N;
    for (int i = 0; i < N; i++) begin
      if (req_v[i]) begin
        int d = (i - last_served - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    bus.cpu_req = req_v;
    bus.cpu_we  = we_v;
    for (int i = 0; i < N; i++) begin
      bus.cpu_addr[i*AW +: AW]  = addr_a[i];
      bus.cpu_wdata[i*DW +: DW] = wdata_a[i];
    end
  endtask

  task automatic wiggle(input int owner);
    for (int i = 0; i < N; i++) begin
      if (i != owner) begin
        addr_a[i]  = AW'($urandom);
        wdata_a[i] = $urandom;
      end
    end
    drive();
  endtask

  // One complete access as seen by the controller model: wait for mem_req, answer after 'delay'.
  task automatic run_access(input int delay, input logic [DW-1:0] rd, output int served, output int waited);
    int e;
    logic ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    e      = model_pick();
    served = e;
    waited = 0;
    if (e < 0) return;
    while (bus.mem_req !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    chk("mem_req_rise", bus.mem_req, 1);
    ew = we_v[e];
    ea = addr_a[e];
    ed = wdata_a[e];
    chk("grant", bus.grant, oh(e));
    chk("mem_we", bus.mem_we, ew);
    chk("mem_addr", bus.mem_addr, ea);
    chk("mem_wdata", bus.mem_wdata, ed);
    chk("busy_access", bus.busy, 1);
    chk("fairness", wait_cnt[e] <= N - 1, 1);
    for (int i = 0; i < N; i++) begin
      if (i != e && req_v[i]) wait_cnt[i]++;
    end
    wait_cnt[e] = 0;
    last_served = e;
    for (int c = 1; c < delay; c++) begin
      wiggle(e);
      tick();
      chk("hold_req", bus.mem_req, 1);
      chk("hold_we", bus.mem_we, ew);
      chk("hold_addr", bus.mem_addr, ea);
      chk("hold_wdata", bus.mem_wdata, ed);
      chk("no_early_vld", bus.cpu_vld, 0);
    end
    wiggle(e);
    bus.mem_vld   = 1'b1;
    bus.mem_rdata = rd;
    tick();
    bus.mem_vld   = 1'b0;
    bus.mem_rdata = $urandom;
    chk("cpu_vld", bus.cpu_vld, oh(e));
    chk("cpu_rdata", bus.cpu_rdata, rd);
    chk("mem_req_drop", bus.mem_req, 0);
    if (!keep_a[e]) begin
      req_v[e] = 1'b0;
      drive();
    end
    tick();
    chk("vld_pulse_end", bus.cpu_vld, 0);
    chk("grant_clear", bus.grant, 0);
    chk("busy_clear", bus.busy, 0);
    chk("rdata_hold", bus.cpu_rdata, rd);
  endtask

  // Continuous properties: at most one completion pulse, controller-side fields stable mid-access.
  logic          prev_req = 1'b0;
  logic          prev_vld = 1'b0;
  logic          prev_rst = 1'b1;
  logic          prev_we  = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_wdata = '0;
  always @(negedge clk) begin
    if (!rst && !prev_rst) begin
      chk("vld_onehot0", $onehot0(bus.cpu_vld), 1);
      if (prev_req && !prev_vld) begin
        chk("mon_req_stable", bus.mem_req, 1);
        chk("mon_we_stable", bus.mem_we, prev_we);
        chk("mon_addr_stable", bus.mem_addr, prev_addr);
        chk("mon_wdata_stable", bus.mem_wdata, prev_wdata);
      end
    end
    prev_req   <= bus.mem_req;
    prev_vld   <= bus.mem_vld;
    prev_rst   <= rst;
    prev_we    <= bus.mem_we;
    prev_addr  <= bus.mem_addr;
    prev_wdata <= bus.mem_wdata;
  end

  initial begin
    int s, w, cnt;
    int order[$];
    rst   = 1'b1;
    req_v = '0;
    we_v  = '0;
    for (int i = 0; i < N; i++) begin
      addr_a[i]   = '0;
      wdata_a[i]  = '0;
      keep_a[i]   = 1'b0;
      wait_cnt[i] = 0;
    end
    drive();
    bus.mem_vld   = 1'b0;
    bus.mem_rdata = '0;
    last_served   = N - 1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_cpu_vld", bus.cpu_vld, 0);
    chk("rst_grant", bus.grant, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);

    // Three-way tie straight after reset: 0, 1, 2.
    for (int i = 0; i < N; i++) begin
      req_v[i]   = 1'b1;
      we_v[i]    = 1'b0;
      addr_a[i]  = AW'(16 * (i + 1));
      wdata_a[i] = 32'hA0 + i;
    end
    drive();
    for (int k = 0; k < N; k++) begin
      run_access(2, 32'h1000 + k, s, w);
      order.push_back(s);
    end
    chk("tie_order0", order[0], 0);
    chk("tie_order1", order[1], 1);
    chk("tie_order2", order[2], 2);

    // Single read from core 1, answered 3 cycles after mem_req.
    req_v[1]  = 1'b1;
    we_v[1]   = 1'b0;
    addr_a[1] = 14'h0010;
    drive();
    run_access(3, 32'hDEADBEEF, s, w);
    chk("read_core", s, 1);
    chk("read_latency", w, 1);

    // Write from core 2 at the top address.
    req_v[2]   = 1'b1;
    we_v[2]    = 1'b1;
    addr_a[2]  = 14'h3FFF;
    wdata_a[2] = 32'h12345678;
    drive();
    run_access(4, 32'h0BAD_F00D, s, w);
    chk("write_core", s, 2);

    // Spurious mem_vld while idle.
    bus.mem_vld   = 1'b1;
    bus.mem_rdata = 32'hFFFF_0000;
    tick();
    bus.mem_vld = 1'b0;
    chk("spur_cpu_vld", bus.cpu_vld, 0);
    chk("spur_busy", bus.busy, 0);
    chk("spur_mem_req", bus.mem_req, 0);
    chk("spur_rdata", bus.cpu_rdata, 32'h0BAD_F00D);
    tick();
    chk("spur_cpu_vld2", bus.cpu_vld, 0);
    chk("spur_busy2", bus.busy, 0);

    // Reset two cycles into an access, then a fresh three-way tie.
    req_v[1] = 1'b1;
    drive();
    tick();
    chk("pre_rst_req", bus.mem_req, 1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_mem_req", bus.mem_req, 0);
    chk("midrst_cpu_vld", bus.cpu_vld, 0);
    chk("midrst_grant", bus.grant, 0);
    chk("midrst_busy", bus.busy, 0);
    req_v = '1;
    drive();
    tick();
    rst         = 1'b0;
    last_served = N - 1;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    run_access(1, 32'h5555_AAAA, s, w);
    chk("post_rst_winner", s, 0);
    run_access(1, 32'h1, s, w);
    run_access(1, 32'h2, s, w);

    // Cores 0 and 2 request continuously; core 1 asks once.
    keep_a[0] = 1'b1;
    keep_a[2] = 1'b1;
    req_v     = 3'b101;
    drive();
    run_access(2, 32'h77, s, w);
    req_v[1] = 1'b1;
    drive();
    cnt = 0;
    s   = -1;
    while (s != 1 && cnt < 4) begin
      run_access($urandom_range(1, 3), $urandom, s, w);
      cnt++;
    end
    chk("starve_core1", cnt <= 2, 1);
    keep_a[0] = 1'b0;
    keep_a[2] = 1'b0;
    req_v     = '0;
    drive();
    tick();
    tick();

    // Randomized traffic against the reference model.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_v[i] && $urandom_range(0, 1) == 1) begin
          req_v[i]    = 1'b1;
          we_v[i]     = 1'($urandom_range(0, 1));
          addr_a[i]   = AW'($urandom);
          wdata_a[i]  = $urandom;
          keep_a[i]   = ($urandom_range(0, 3) == 0);
          wait_cnt[i] = 0;
        end
      end
      if (req_v == '0) begin
        int j = $urandom_range(0, N - 1);
        req_v[j]    = 1'b1;
        wait_cnt[j] = 0;
        keep_a[j]   = 1'b0;
      end
      drive();
      run_access($urandom_range(1, 4), $urandom, s, w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
